// File: rtl/simon_ti_serial_ctrl.sv
// Sequencer for a 2-share bit-serial Simon128/128 core.
// It latches key and plaintext shares, streams them LSB first using the
// data_rdy phase code, waits for Done and then deserialises both ciphertext
// shares. The result is presented with a valid/ready handshake.
// The A and B share paths stay in separate registers and are never combined.
module simon_ti_serial_ctrl #(
  parameter int unsigned BLK_W   = 128,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned MAX_RUN = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [BLK_W-1:0] key_a_i,
  input  logic [BLK_W-1:0] key_b_i,
  input  logic [BLK_W-1:0] pt_a_i,
  input  logic [BLK_W-1:0] pt_b_i,
  output logic             busy_o,
  output logic             core_data_ina_o,
  output logic             core_data_inb_o,
  output logic [1:0]       core_data_rdy_o,
  input  logic             core_cipher_outa_i,
  input  logic             core_cipher_outb_i,
  input  logic             core_done_i,
  output logic [BLK_W-1:0] ct_a_o,
  output logic [BLK_W-1:0] ct_b_o,
  output logic             ct_valid_o,
  input  logic             ct_ready_i,
  output logic             timeout_err_o
);

  // The run counter must be able to hold MAX_RUN-1; CNT_W must cover BLK_W-1.
  localparam int unsigned RUN_W = $clog2(MAX_RUN + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BLK_W - 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MAX_RUN - 1);

  // Phase codes presented to the core.
  localparam logic [1:0] RDY_IDLE = 2'b00;
  localparam logic [1:0] RDY_KEY  = 2'b10;
  localparam logic [1:0] RDY_PT   = 2'b01;
  localparam logic [1:0] RDY_RUN  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_KEY,
    S_LOAD_PT,
    S_RUN,
    S_COLLECT,
    S_HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;

  // Latched shares; each is consumed by shifting right one bit per load cycle.
  logic [BLK_W-1:0] key_a_q, key_a_d;
  logic [BLK_W-1:0] key_b_q, key_b_d;
  logic [BLK_W-1:0] pt_a_q, pt_a_d;
  logic [BLK_W-1:0] pt_b_q, pt_b_d;

  // Ciphertext deserialisers, filled from the MSB end.
  logic [BLK_W-1:0] ct_a_q, ct_a_d;
  logic [BLK_W-1:0] ct_b_q, ct_b_d;

  logic       busy_q, busy_d;
  logic       ina_q, ina_d;
  logic       inb_q, inb_d;
  logic [1:0] rdy_q, rdy_d;
  logic       valid_q, valid_d;
  logic       tmo_q, tmo_d;

  // State and datapath registers; reset clears everything, including shares.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      run_cnt_q <= '0;
      key_a_q   <= '0;
      key_b_q   <= '0;
      pt_a_q    <= '0;
      pt_b_q    <= '0;
      ct_a_q    <= '0;
      ct_b_q    <= '0;
      busy_q    <= 1'b0;
      ina_q     <= 1'b0;
      inb_q     <= 1'b0;
      rdy_q     <= RDY_IDLE;
      valid_q   <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      run_cnt_q <= run_cnt_d;
      key_a_q   <= key_a_d;
      key_b_q   <= key_b_d;
      pt_a_q    <= pt_a_d;
      pt_b_q    <= pt_b_d;
      ct_a_q    <= ct_a_d;
      ct_b_q    <= ct_b_d;
      busy_q    <= busy_d;
      ina_q     <= ina_d;
      inb_q     <= inb_d;
      rdy_q     <= rdy_d;
      valid_q   <= valid_d;
      tmo_q     <= tmo_d;
    end
  end

  // Next-state logic; registered outputs are computed for the cycle being entered.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    run_cnt_d = run_cnt_q;
    key_a_d   = key_a_q;
    key_b_d   = key_b_q;
    pt_a_d    = pt_a_q;
    pt_b_d    = pt_b_q;
    ct_a_d    = ct_a_q;
    ct_b_d    = ct_b_q;
    busy_d    = busy_q;
    ina_d     = 1'b0;
    inb_d     = 1'b0;
    rdy_d     = rdy_q;
    valid_d   = valid_q;
    tmo_d     = tmo_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          key_a_d = key_a_i;
          key_b_d = key_b_i;
          pt_a_d  = pt_a_i;
          pt_b_d  = pt_b_i;
          cnt_d   = '0;
          tmo_d   = 1'b0;
          busy_d  = 1'b1;
          rdy_d   = RDY_KEY;
          ina_d   = key_a_i[0];
          inb_d   = key_b_i[0];
          state_d = S_LOAD_KEY;
        end
      end

      S_LOAD_KEY: begin
        key_a_d = key_a_q >> 1;
        key_b_d = key_b_q >> 1;
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          rdy_d   = RDY_PT;
          ina_d   = pt_a_q[0];
          inb_d   = pt_b_q[0];
          state_d = S_LOAD_PT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          ina_d = key_a_q[1];
          inb_d = key_b_q[1];
        end
      end

      S_LOAD_PT: begin
        pt_a_d = pt_a_q >> 1;
        pt_b_d = pt_b_q >> 1;
        if (cnt_q == LAST_BIT) begin
          cnt_d     = '0;
          run_cnt_d = '0;
          rdy_d     = RDY_RUN;
          state_d   = S_RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          ina_d = pt_a_q[1];
          inb_d = pt_b_q[1];
        end
      end

      // Done takes priority over the timeout on the final allowed cycle.
      S_RUN: begin
        if (core_done_i) begin
          ct_a_d  = {core_cipher_outa_i, ct_a_q[BLK_W-1:1]};
          ct_b_d  = {core_cipher_outb_i, ct_b_q[BLK_W-1:1]};
          cnt_d   = CNT_W'(1);
          state_d = S_COLLECT;
        end else if (run_cnt_q == RUN_LAST) begin
          tmo_d   = 1'b1;
          busy_d  = 1'b0;
          rdy_d   = RDY_IDLE;
          state_d = S_IDLE;
        end else begin
          run_cnt_d = run_cnt_q + RUN_W'(1);
        end
      end

      // Done is not re-checked here; the core streams one bit per cycle.
      S_COLLECT: begin
        ct_a_d = {core_cipher_outa_i, ct_a_q[BLK_W-1:1]};
        ct_b_d = {core_cipher_outb_i, ct_b_q[BLK_W-1:1]};
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          valid_d = 1'b1;
          rdy_d   = RDY_IDLE;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_HOLD: begin
        if (valid_q && ct_ready_i) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        rdy_d   = RDY_IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // Outputs come straight from registers.
  assign busy_o          = busy_q;
  assign core_data_ina_o = ina_q;
  assign core_data_inb_o = inb_q;
  assign core_data_rdy_o = rdy_q;
  assign ct_a_o          = ct_a_q;
  assign ct_b_o          = ct_b_q;
  assign ct_valid_o      = valid_q;
  assign timeout_err_o   = tmo_q;

endmodule

// File: tb/tb_simon_ti_serial_ctrl.sv
// Directed bench for simon_ti_serial_ctrl with a behavioural Simon128/128 core stub.
module tb_simon_ti_serial_ctrl;

  localparam int unsigned BLK_W   = 128;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned MAX_RUN = 16;

  localparam logic [127:0] KAT_KEY = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] KAT_PT  = 128'h63736564207372656c6c657661727420;
  localparam logic [127:0] KAT_CT  = 128'h49681b1e1e54fe3f65aa832af84e0bbc;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [BLK_W-1:0] key_a = '0, key_b = '0, pt_a = '0, pt_b = '0;
  logic             busy;
  logic             core_ina, core_inb;
  logic [1:0]       core_rdy;
  logic             core_ca = 1'b0, core_cb = 1'b0, core_done = 1'b0;
  logic [BLK_W-1:0] ct_a, ct_b;
  logic             ct_valid;
  logic             ct_ready = 1'b0;
  logic             tmo;

  int n_checks = 0;
  int n_fails  = 0;

  // Core stub state
  logic [127:0] rx_ka = '0, rx_kb = '0, rx_pa = '0, rx_pb = '0;
  logic [127:0] stub_sh_a = '0, stub_sh_b = '0, stub_mask = '0;
  bit           stub_running = 1'b0;
  bit           never_done = 1'b0;
  int           stub_run_cyc = 0;
  int           stub_left = 0;
  int           done_delay = 0;

  simon_ti_serial_ctrl #(.BLK_W(BLK_W), .CNT_W(CNT_W), .MAX_RUN(MAX_RUN)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start),
    .key_a_i(key_a), .key_b_i(key_b), .pt_a_i(pt_a), .pt_b_i(pt_b),
    .busy_o(busy),
    .core_data_ina_o(core_ina), .core_data_inb_o(core_inb), .core_data_rdy_o(core_rdy),
    .core_cipher_outa_i(core_ca), .core_cipher_outb_i(core_cb), .core_done_i(core_done),
    .ct_a_o(ct_a), .ct_b_o(ct_b), .ct_valid_o(ct_valid), .ct_ready_i(ct_ready),
    .timeout_err_o(tmo)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reference Simon128/128 encryption.
  function automatic logic [127:0] simon_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [63:0] k [0:67];
    logic [63:0] x, y, t;
    logic [61:0] zr;
    zr   = 62'b10101111011100000011010010011000101000010001111110010110110011;
    k[0] = key[63:0];
    k[1] = key[127:64];
    for (int i = 0; i < 66; i++) begin
      t = {k[i+1][2:0], k[i+1][63:3]};
      t = t ^ {t[0], t[63:1]};
      k[i+2] = ~k[i] ^ t ^ {63'd0, zr[61]} ^ 64'd3;
      zr = {zr[60:0], zr[61]};
    end
    x = pt[127:64];
    y = pt[63:0];
    for (int i = 0; i < 68; i++) begin
      t = x;
      x = y ^ ({x[62:0], x[63]} & {x[55:0], x[63:56]}) ^ {x[61:0], x[63:62]} ^ k[i];
      y = t;
    end
    return {x, y};
  endfunction

  // Core stub: collects loaded shares, then after done_delay RUN cycles raises
  // Done and streams a freshly masked ciphertext, LSB first.
  always @(negedge clk) begin
    case (core_rdy)
      2'b10: begin
        rx_ka = {core_ina, rx_ka[127:1]};
        rx_kb = {core_inb, rx_kb[127:1]};
      end
      2'b01: begin
        rx_pa = {core_ina, rx_pa[127:1]};
        rx_pb = {core_inb, rx_pb[127:1]};
      end
      2'b11: begin
        if (!stub_running) begin
          stub_sh_b    = stub_mask;
          stub_sh_a    = simon_enc(rx_ka ^ rx_kb, rx_pa ^ rx_pb) ^ stub_mask;
          stub_running = 1'b1;
          stub_run_cyc = 0;
          stub_left    = 128;
        end
        if (!never_done && stub_run_cyc >= done_delay && stub_left > 0) begin
          core_done = 1'b1;
          core_ca   = stub_sh_a[0];
          core_cb   = stub_sh_b[0];
          stub_sh_a = stub_sh_a >> 1;
          stub_sh_b = stub_sh_b >> 1;
          stub_left--;
        end else if (stub_left == 0) begin
          core_done = 1'b0;
        end
        stub_run_cyc++;
      end
      default: begin
        stub_running = 1'b0;
        core_done    = 1'b0;
        core_ca      = 1'b0;
        core_cb      = 1'b0;
      end
    endcase
  end

  // Pulses start for one edge; returns at the negedge of the first load cycle.
  task automatic do_start(input logic [127:0] ka, input logic [127:0] kb,
                          input logic [127:0] pa, input logic [127:0] pb);
    @(negedge clk);
    key_a = ka; key_b = kb; pt_a = pa; pt_b = pb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for ct_valid; w is the number of negedges waited, busy_ok tracks busy.
  task automatic wait_valid(input int budget, output int w, output bit ok, output bit busy_ok);
    ok = 1'b0; busy_ok = 1'b1; w = 0;
    for (int i = 0; i < budget; i++) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (ct_valid === 1'b1) begin
        ok = 1'b1; w = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  // One full operation with masked shares, checked against exp_ct.
  task automatic test_op(input string nm, input logic [127:0] k, input logic [127:0] p,
                         input logic [127:0] km, input logic [127:0] pm,
                         input int delay, input logic [127:0] exp_ct);
    int w; bit ok, busy_ok;
    done_delay = delay;
    stub_mask  = rand128();
    do_start(k ^ km, km, p ^ pm, pm);
    wait_valid(700, w, ok, busy_ok);
    n_checks++;
    if (!ok) begin
      n_fails++;
      $display("FAIL %s_valid: ct_valid never rose within budget", nm);
    end else begin
      n_checks++;
      if ((ct_a ^ ct_b) !== exp_ct) begin
        n_fails++;
        $display("FAIL %s_ct: got %h want %h", nm, ct_a ^ ct_b, exp_ct);
      end
      n_checks++;
      if (1 + w !== 3 * BLK_W + 1 + delay) begin
        n_fails++;
        $display("FAIL %s_latency: got %0d want %0d", nm, 1 + w, 3 * BLK_W + 1 + delay);
      end
      n_checks++;
      if (!busy_ok) begin
        n_fails++;
        $display("FAIL %s_busy: busy dropped during operation, want 1 throughout", nm);
      end
      ct_ready = 1'b1;
      @(negedge clk);
      ct_ready = 1'b0;
      n_checks++;
      if (ct_valid !== 1'b0 || busy !== 1'b0) begin
        n_fails++;
        $display("FAIL %s_handshake: valid=%b busy=%b want 0 0", nm, ct_valid, busy);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || ct_valid !== 1'b0 || tmo !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_flags: busy=%b valid=%b tmo=%b want 0 0 0", busy, ct_valid, tmo);
    end
    n_checks++;
    if (core_rdy !== 2'b00 || core_ina !== 1'b0 || core_inb !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_core_if: rdy=%b ina=%b inb=%b want 00 0 0", core_rdy, core_ina, core_inb);
    end
    n_checks++;
    if (ct_a !== '0 || ct_b !== '0) begin
      n_fails++;
      $display("FAIL reset_ct: ct_a=%h ct_b=%h want 0", ct_a, ct_b);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_kat();
    test_op("kat", KAT_KEY, KAT_PT, '0, '0, 0, KAT_CT);
  endtask

  task automatic test_load_seq();
    logic [127:0] ka, kb, pa, pb, sa, sb;
    int n10, n01, kerr, perr, w;
    bit ok, busy_ok;
    logic [1:0] rdy_run;
    ka = rand128(); kb = rand128(); pa = rand128(); pb = rand128();
    n10 = 0; n01 = 0; kerr = 0; perr = 0; rdy_run = 2'b00;
    done_delay = 4;
    stub_mask  = rand128();
    do_start(ka, kb, pa, pb);
    sa = ka; sb = kb;
    for (int c = 1; c <= 257; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 129) begin sa = pa; sb = pb; end
      if (c <= 128) begin
        if (core_rdy === 2'b10) n10++;
        if (core_ina !== sa[0] || core_inb !== sb[0]) kerr++;
      end else if (c <= 256) begin
        if (core_rdy === 2'b01) n01++;
        if (core_ina !== sa[0] || core_inb !== sb[0]) perr++;
      end else begin
        rdy_run = core_rdy;
      end
      sa = sa >> 1; sb = sb >> 1;
      if (c == 1) begin
        key_a = ~ka; key_b = rand128(); pt_a = ~pa; pt_b = rand128();
      end
    end
    n_checks++;
    if (n10 !== 128) begin n_fails++; $display("FAIL load_key_len: got %0d cycles of 10 want 128", n10); end
    n_checks++;
    if (n01 !== 128) begin n_fails++; $display("FAIL load_pt_len: got %0d cycles of 01 want 128", n01); end
    n_checks++;
    if (rdy_run !== 2'b11) begin n_fails++; $display("FAIL load_run_code: got %b want 11", rdy_run); end
    n_checks++;
    if (kerr !== 0) begin n_fails++; $display("FAIL load_key_bits: got %0d bit errors want 0", kerr); end
    n_checks++;
    if (perr !== 0) begin n_fails++; $display("FAIL load_pt_bits: got %0d bit errors want 0", perr); end
    wait_valid(300, w, ok, busy_ok);
    n_checks++;
    if (!ok || (ct_a ^ ct_b) !== simon_enc(ka ^ kb, pa ^ pb)) begin
      n_fails++;
      $display("FAIL load_result: valid=%b got %h want %h", ok, ct_a ^ ct_b, simon_enc(ka ^ kb, pa ^ pb));
    end
    ct_ready = 1'b1;
    @(negedge clk);
    ct_ready = 1'b0;
  endtask

  task automatic test_masking();
    logic [127:0] k, p;
    for (int i = 0; i < 20; i++) begin
      k = rand128(); p = rand128();
      test_op($sformatf("mask%0d", i), k, p, rand128(), rand128(), i % 16, simon_enc(k, p));
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] snap_a, snap_b, k, p;
    int w; bit ok, busy_ok;
    k = rand128(); p = rand128();
    done_delay = 2;
    stub_mask  = rand128();
    do_start(k, '0, p, '0);
    wait_valid(700, w, ok, busy_ok);
    n_checks++;
    if (!ok) begin
      n_fails++;
      $display("FAIL bp_valid: ct_valid never rose within budget");
    end else begin
      snap_a = ct_a; snap_b = ct_b;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        n_checks++;
        if (ct_valid !== 1'b1 || busy !== 1'b1 || ct_a !== snap_a || ct_b !== snap_b) begin
          n_fails++;
          $display("FAIL bp_hold%0d: valid=%b busy=%b ct_a=%h want valid/busy 1 and ct_a %h",
                   i, ct_valid, busy, ct_a, snap_a);
        end
        start = (i == 20);
      end
      start = 1'b0;
      ct_ready = 1'b1;
      @(negedge clk);
      ct_ready = 1'b0;
      n_checks++;
      if (ct_valid !== 1'b0 || busy !== 1'b0 || ct_a !== snap_a || ct_b !== snap_b) begin
        n_fails++;
        $display("FAIL bp_release: valid=%b busy=%b ct kept=%b want 0 0 1",
                 ct_valid, busy, (ct_a === snap_a && ct_b === snap_b));
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || core_rdy !== 2'b00) begin
        n_fails++;
        $display("FAIL bp_no_queue: busy=%b rdy=%b want 0 00", busy, core_rdy);
      end
    end
  endtask

  task automatic test_timeout();
    int run_start, t_cyc, w;
    bit saw_valid, busy_at_t, ok, busy_ok;
    logic [1:0] rdy_at_t;
    run_start = 0; t_cyc = 0; saw_valid = 1'b0; busy_at_t = 1'b1; rdy_at_t = 2'b11;
    never_done = 1'b1;
    do_start(rand128(), rand128(), rand128(), rand128());
    for (int c = 1; c <= 290; c++) begin
      if (c > 1) @(negedge clk);
      if (ct_valid === 1'b1) saw_valid = 1'b1;
      if (core_rdy === 2'b11 && run_start == 0) run_start = c;
      if (tmo === 1'b1 && t_cyc == 0) begin
        t_cyc = c; busy_at_t = busy; rdy_at_t = core_rdy;
      end
    end
    never_done = 1'b0;
    n_checks++;
    if (run_start !== 2 * BLK_W + 1) begin
      n_fails++; $display("FAIL tmo_run_entry: got cycle %0d want %0d", run_start, 2 * BLK_W + 1);
    end
    n_checks++;
    if (t_cyc - run_start !== 16) begin
      n_fails++; $display("FAIL tmo_delay: got %0d cycles into RUN want 16", t_cyc - run_start);
    end
    n_checks++;
    if (busy_at_t !== 1'b0 || rdy_at_t !== 2'b00) begin
      n_fails++; $display("FAIL tmo_idle: busy=%b rdy=%b want 0 00", busy_at_t, rdy_at_t);
    end
    n_checks++;
    if (saw_valid) begin n_fails++; $display("FAIL tmo_valid: ct_valid rose, want never"); end
    n_checks++;
    if (tmo !== 1'b1) begin n_fails++; $display("FAIL tmo_sticky: got %b want 1", tmo); end
    done_delay = 1;
    stub_mask  = rand128();
    do_start(KAT_KEY, '0, KAT_PT, '0);
    n_checks++;
    if (tmo !== 1'b0) begin n_fails++; $display("FAIL tmo_clear: got %b want 0", tmo); end
    wait_valid(700, w, ok, busy_ok);
    n_checks++;
    if (!ok || (ct_a ^ ct_b) !== KAT_CT) begin
      n_fails++; $display("FAIL tmo_recover: valid=%b got %h want %h", ok, ct_a ^ ct_b, KAT_CT);
    end
    ct_ready = 1'b1;
    @(negedge clk);
    ct_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    // Reset while key bit 60 is on the wire.
    done_delay = 0;
    stub_mask  = rand128();
    do_start(KAT_KEY, rand128(), KAT_PT, rand128());
    repeat (60) @(negedge clk);
    n_checks++;
    if (core_rdy !== 2'b10) begin n_fails++; $display("FAIL rstk_phase: rdy=%b want 10", core_rdy); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, core_ina, core_inb, core_rdy, ct_valid, tmo} !== 7'd0 || ct_a !== '0 || ct_b !== '0) begin
      n_fails++;
      $display("FAIL rstk_async: busy=%b ina=%b inb=%b rdy=%b valid=%b tmo=%b want all 0",
               busy, core_ina, core_inb, core_rdy, ct_valid, tmo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_op("rstk_kat", KAT_KEY, KAT_PT, rand128(), rand128(), 2, KAT_CT);
    // Reset in the middle of ciphertext collection.
    done_delay = 0;
    stub_mask  = rand128();
    do_start(KAT_KEY, '0, KAT_PT, '0);
    repeat (2 * BLK_W + 60) @(negedge clk);
    n_checks++;
    if (core_rdy !== 2'b11 || ct_valid !== 1'b0) begin
      n_fails++; $display("FAIL rstc_phase: rdy=%b valid=%b want 11 0", core_rdy, ct_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, core_ina, core_inb, core_rdy, ct_valid, tmo} !== 7'd0 || ct_a !== '0 || ct_b !== '0) begin
      n_fails++;
      $display("FAIL rstc_async: busy=%b rdy=%b valid=%b ct_a=%h ct_b=%h want all 0",
               busy, core_rdy, ct_valid, ct_a, ct_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_op("rstc_kat", KAT_KEY, KAT_PT, '0, '0, 0, KAT_CT);
  endtask

  initial begin
    test_reset();
    test_kat();
    test_load_seq();
    test_masking();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
